// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// leading-zero blank flags; bcd/blank are held until the next conversion completes.
module bcd_display_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     CNT_LOAD  = CW'(WIDTH);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [CW-1:0]       count_r;
  logic [WIDTH-1:0]    shift_r;
  logic [BW-1:0]       scratch_r;
  logic [BW-1:0]       adj_s;
  logic [BW-1:0]       scratch_next_s;
  logic [WIDTH-1:0]    shift_next_s;
  logic                busy_r;
  logic                done_r;
  logic [BW-1:0]       bcd_r;
  logic [DIGITS-1:0]   blank_r;

  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Digit i (i >= 1) blanks only when it and every more significant digit are zero.
  function automatic logic [DIGITS-1:0] blank_flags(input logic [BW-1:0] s);
    logic [DIGITS-1:0] b;
    logic              upper_zero;
    b          = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (s[4*i +: 4] == 4'd0);
      b[i]       = upper_zero;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  // One double-dabble step: correct digits, then shift the combined register left.
  always_comb begin
    adj_s          = add3_all(scratch_r);
    scratch_next_s = {adj_s[BW-2:0], shift_r[WIDTH-1]};
    shift_next_s   = {shift_r[WIDTH-2:0], 1'b0};
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = SHIFT;
        else       next_state_s = IDLE;
      end
      SHIFT: begin
        if (count_r == CNT_ONE) next_state_s = DONE;
        else                    next_state_s = SHIFT;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= '0;
      shift_r   <= '0;
      scratch_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= '0;
      blank_r   <= BLANK_RST;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            shift_r   <= bin;
            scratch_r <= '0;
            count_r   <= CNT_LOAD;
          end
        end
        SHIFT: begin
          shift_r   <= shift_next_s;
          scratch_r <= scratch_next_s;
          count_r   <= count_r - CNT_ONE;
        end
        DONE: begin
          bcd_r   <= scratch_r;
          blank_r <= blank_flags(scratch_r);
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign bcd   = bcd_r;
  assign blank = blank_r;

endmodule

// File: tb/tb_bcd_display_converter.sv
// Self-checking bench for bcd_display_converter: directed cases plus back-to-back
// random conversions checked against a decimal-arithmetic reference model.
module tb_bcd_display_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic [5:0]  blank;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] held_bcd;
  logic [5:0]  held_blank;

  always #5 clk = ~clk;

  bcd_display_converter #(.WIDTH(16), .DIGITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_blank(input int unsigned v);
    logic [5:0]  b;
    int unsigned p;
    b = '0;
    p = 1;
    for (int i = 1; i < 6; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] v);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("done_low_after_accept", {31'd0, done}, 32'd0);
  endtask

  task automatic finish_conv(input logic [15:0] v, input int j0);
    int j;
    j = j0;
    while (!done && j < 40) begin
      chk("busy_during_conv", {31'd0, busy}, 32'd1);
      chk("bcd_stable", {8'd0, bcd}, {8'd0, held_bcd});
      chk("blank_stable", {26'd0, blank}, {26'd0, held_blank});
      @(negedge clk);
      j++;
    end
    chk("done_latency", j, 32'd17);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    chk("bcd_result", {8'd0, bcd}, {8'd0, ref_bcd(v)});
    chk("blank_result", {26'd0, blank}, {26'd0, ref_blank(v)});
    held_bcd   = ref_bcd(v);
    held_blank = ref_blank(v);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done_low", {31'd0, done}, 32'd0);
      chk("idle_busy_low", {31'd0, busy}, 32'd0);
      chk("idle_bcd_hold", {8'd0, bcd}, {8'd0, held_bcd});
      chk("idle_blank_hold", {26'd0, blank}, {26'd0, held_blank});
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] edges [10];
    edges = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000,
              16'd9999, 16'd10000, 16'd65535};

    reset      = 1'b1;
    start      = 1'b0;
    bin        = 16'd0;
    held_bcd   = 24'h000000;
    held_blank = 6'b111110;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {8'd0, bcd}, 32'h0);
    chk("rst_blank", {26'd0, blank}, 32'h3e);
    @(negedge clk);
    reset = 1'b0;

    // Zero: latency, busy window, blank with digit 0 shown
    launch(16'd0);
    finish_conv(16'd0, 0);
    chk("zero_blank_const", {26'd0, blank}, 32'h3e);
    idle_cycles(2);

    launch(16'd65535);
    finish_conv(16'd65535, 0);
    chk("max_bcd_const", {8'd0, bcd}, 32'h065535);
    chk("max_blank_const", {26'd0, blank}, 32'h20);
    idle_cycles(2);

    launch(16'd1234);
    finish_conv(16'd1234, 0);
    chk("b1234_blank_const", {26'd0, blank}, 32'h30);
    idle_cycles(2);

    // Start while busy must be ignored, with no queued second conversion
    launch(16'd42);
    repeat (5) @(negedge clk);
    start = 1'b1;
    bin   = 16'd9999;
    @(negedge clk);
    start = 1'b0;
    finish_conv(16'd42, 6);
    chk("ignored_bcd_const", {8'd0, bcd}, 32'h000042);
    idle_cycles(20);

    // Start in the done cycle is accepted
    launch(16'd555);
    finish_conv(16'd555, 0);
    launch(16'd100);
    finish_conv(16'd100, 0);
    chk("b100_blank_const", {26'd0, blank}, 32'h38);
    idle_cycles(2);

    // Asynchronous reset mid-conversion
    launch(16'd5000);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_bcd", {8'd0, bcd}, 32'h0);
    chk("midrst_blank", {26'd0, blank}, 32'h3e);
    @(negedge clk);
    reset      = 1'b0;
    held_bcd   = 24'h000000;
    held_blank = 6'b111110;
    idle_cycles(25);
    launch(16'd7);
    finish_conv(16'd7, 0);
    chk("after_rst_bcd_const", {8'd0, bcd}, 32'h000007);

    // Back-to-back boundary values followed by random values
    for (int i = 0; i < 250; i++) begin
      if (i < 10) v = edges[i];
      else        v = 16'($urandom_range(65535, 0));
      launch(v);
      finish_conv(v, 0);
    end
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
